// File: rtl/alu_operand_loader_pkg.sv
// rtl/alu_operand_loader_pkg.sv - shared op codes, FSM states and frame constants for the operand loader
package alu_operand_loader_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_CHECK  = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_WAIT   = 3'd5,
        ST_SEND   = 3'd6
    } state_e;

    localparam logic [3:0] OP_MAX               = OP_AND;
    localparam int         OPERAND_BYTES        = 4;
    localparam int         RESULT_BYTES         = 4;
    localparam int         FRAME_BYTES_BASE     = 1 + 2 * OPERAND_BYTES;
    localparam int         FRAME_BYTES_CHECKSUM = FRAME_BYTES_BASE + 1;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - 32-bit result to LSB-first byte stream with valid/ready handshake
module alu_result_serializer
    import alu_operand_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    output logic [7:0]  out_tdata_o,
    output logic        out_tvalid_o,
    input  logic        out_tready_i,
    output logic        done_o
);

    localparam logic [1:0] LAST_BYTE = 2'(RESULT_BYTES - 1);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        fire;

    assign fire         = ena_i && valid_q && out_tready_i;
    assign out_tdata_o  = shift_q[7:0];
    assign out_tvalid_o = valid_q;
    assign done_o       = fire && (cnt_q == LAST_BYTE);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = load_data_i;
            cnt_d   = 2'd0;
            valid_d = 1'b1;
        end else if (fire) begin
            // Byte 0 always sits in the low lane so out_tdata holds while stalled.
            shift_d = {8'h00, shift_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == LAST_BYTE) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= 32'd0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (ena_i) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - byte-serial ALU request loader; optional checksum byte under ALU_LOADER_CHECKSUM_EN
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     LAST_BYTE = 2'(OPERAND_BYTES - 1);

    state_e         state_q, state_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [3:0]     op_q, op_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic           err_q, err_d;
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
`ifdef ALU_LOADER_CHECKSUM_EN
    logic [7:0]     csum_q, csum_d;
`endif

    logic           in_fire;
    logic           ser_load;
    logic           ser_valid;
    logic           ser_done;

    assign in_ready  = rst_n && ena &&
                       (state_q inside {ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_CHECK});
    assign in_fire   = in_valid && in_ready;
    assign alu_start = ena && (state_q == ST_ISSUE);
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign err       = err_q;
    assign out_valid = ena && ser_valid;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        ser_load   = 1'b0;
`ifdef ALU_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    op_d       = in_data[3:0];
                    err_d      = 1'b0;
                    byte_cnt_d = 2'd0;
                    state_d    = ST_LOAD_A;
`ifdef ALU_LOADER_CHECKSUM_EN
                    csum_d     = in_data;
`endif
                end
            end
            ST_LOAD_A: begin
                if (in_fire) begin
                    a_d[8*byte_cnt_q +: 8] = in_data;
                    byte_cnt_d             = byte_cnt_q + 2'd1;
`ifdef ALU_LOADER_CHECKSUM_EN
                    csum_d                 = csum_q ^ in_data;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_B: begin
                if (in_fire) begin
                    b_d[8*byte_cnt_q +: 8] = in_data;
                    byte_cnt_d             = byte_cnt_q + 2'd1;
`ifdef ALU_LOADER_CHECKSUM_EN
                    csum_d                 = csum_q ^ in_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (op_is_legal(op_q)) begin
                            state_d = ST_ISSUE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
`endif
                end
            end
            ST_CHECK: begin
`ifdef ALU_LOADER_CHECKSUM_EN
                if (in_fire) begin
                    if ((in_data == csum_q) && op_is_legal(op_q)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A done strobe on the timeout cycle still wins over the abort.
                if (alu_done) begin
                    ser_load = ena;
                    state_d  = ST_SEND;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            op_q       <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
`ifdef ALU_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else if (ena) begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef ALU_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    alu_result_serializer u_serializer (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena),
        .load_i       (ser_load),
        .load_data_i  (alu_result),
        .out_tdata_o  (out_data),
        .out_tvalid_o (ser_valid),
        .out_tready_i (out_ready),
        .done_o       (ser_done)
    );

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;
    import alu_operand_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    alu_operand_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    always @(negedge clk) begin
        if (alu_start) start_cnt++;
        if (out_valid && out_ready) rx_q.push_back(out_data);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        logic rdy = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        total++;
        if (!rdy) begin
            bad++;
            $display("FAIL send_byte: in_ready=%0b for byte %02h, required 1", rdy, b);
        end
    endtask

    task automatic send_operands(input logic [7:0] opb, input logic [31:0] a, input logic [31:0] b,
                                 input bit bad_csum);
        logic [7:0] c = opb;
        for (int i = 0; i < OPERAND_BYTES; i++) begin
            send_byte(a[8*i +: 8]);
            c = c ^ a[8*i +: 8];
        end
        for (int i = 0; i < OPERAND_BYTES; i++) begin
            send_byte(b[8*i +: 8]);
            c = c ^ b[8*i +: 8];
        end
`ifdef ALU_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? 8'hFF : c);
`endif
    endtask

    task automatic send_frame(input logic [7:0] opb, input logic [31:0] a, input logic [31:0] b,
                              input bit bad_csum);
        send_byte(opb);
        send_operands(opb, a, b, bad_csum);
    endtask

    // Caller must already be in WAIT.
    task automatic pulse_done(input logic [31:0] res);
        alu_done   = 1'b1;
        alu_result = res;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL done_to_valid: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic drain(input int n);
        int k = 0;
        out_ready = 1'b1;
        while (rx_q.size() < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        out_ready = 1'b0;
        total++;
        if (rx_q.size() < n) begin
            bad++;
            $display("FAIL drain: got %0d bytes required %0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, alu_start, out_valid, err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: {in_ready,alu_start,out_valid,err}=%b required 0000",
                     {in_ready, alu_start, out_valid, err});
        end
        total++;
        if ({alu_op, out_data} !== 12'h000) begin
            bad++;
            $display("FAIL reset_op_data: op=%h out_data=%h required 0", alu_op, out_data);
        end
        total++;
        if ({alu_a, alu_b} !== 64'd0) begin
            bad++;
            $display("FAIL reset_operands: a=%h b=%h required 0", alu_a, alu_b);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_add();
        int s = start_cnt;
        rx_q.delete();
        send_frame(8'h00, 32'd5, 32'd7, 1'b0);
        total++;
        if (alu_start !== 1'b1) begin
            bad++;
            $display("FAIL add_start_latency: alu_start=%0b required 1", alu_start);
        end
        total++;
        if ({alu_op, alu_a, alu_b} !== {4'd0, 32'd5, 32'd7}) begin
            bad++;
            $display("FAIL add_operands: op=%h a=%h b=%h required 0 5 7", alu_op, alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        total++;
        if (alu_start !== 1'b0) begin
            bad++;
            $display("FAIL add_start_pulse: alu_start=%0b required 0", alu_start);
        end
        pulse_done(32'h0000000C);
        drain(4);
        total++;
        if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h0C000000) begin
            bad++;
            $display("FAIL add_result_bytes: got %h %h %h %h required 0C 00 00 00",
                     rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
        end
        total++;
        if (start_cnt - s !== 1) begin
            bad++;
            $display("FAIL add_start_count: got %0d required 1", start_cnt - s);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL add_back_idle: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_illegal_op();
        int s = start_cnt;
        rx_q.delete();
        send_frame(8'h0C, 32'h11111111, 32'h22222222, 1'b0);
        total++;
        if ({alu_start, err} !== 2'b01) begin
            bad++;
            $display("FAIL illegal_err: alu_start=%0b err=%0b required 0 1", alu_start, err);
        end
        @(posedge clk);
        #1;
        total++;
        if (start_cnt !== s || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL illegal_no_issue: starts=%0d in_ready=%0b required 0 1",
                     start_cnt - s, in_ready);
        end
        // Upper nibble of the opcode byte is ignored: 0x31 is SUB.
        send_byte(8'h31);
        total++;
        if ({err, alu_op} !== {1'b0, 4'd1}) begin
            bad++;
            $display("FAIL illegal_err_clear: err=%0b op=%h required 0 1", err, alu_op);
        end
        send_operands(8'h31, 32'd10, 32'd3, 1'b0);
        total++;
        if ({alu_start, alu_a, alu_b} !== {1'b1, 32'd10, 32'd3}) begin
            bad++;
            $display("FAIL sub_issue: start=%0b a=%h b=%h required 1 a b", alu_start, alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        pulse_done(32'd7);
        drain(4);
        total++;
        if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h07000000) begin
            bad++;
            $display("FAIL sub_result_bytes: got %h %h %h %h required 07 00 00 00",
                     rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
        end
    endtask

    task automatic test_timeout();
        send_frame(8'h02, 32'd1, 32'd4, 1'b0);
        total++;
        if (alu_start !== 1'b1) begin
            bad++;
            $display("FAIL timeout_issue: alu_start=%0b required 1", alu_start);
        end
        // One edge into WAIT, then 15 WAIT cycles: still waiting.
        repeat (16) @(posedge clk);
        #1;
        total++;
        if ({err, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_early: err=%0b in_ready=%0b required 0 0", err, in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if ({err, in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL timeout_abort: err=%0b in_ready=%0b required 1 1", err, in_ready);
        end
        total++;
        if (alu_a !== 32'd1 || alu_op !== 4'd2) begin
            bad++;
            $display("FAIL timeout_operands_held: a=%h op=%h required 1 2", alu_a, alu_op);
        end
        alu_done = 1'b1;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray_done: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        rx_q.delete();
        send_frame(8'h08, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
        @(posedge clk);
        #1;
        pulse_done(32'hA1B2C3D4);
        total++;
        if (out_data !== 8'hD4) begin
            bad++;
            $display("FAIL bp_first_byte: out_data=%h required D4", out_data);
        end
        drain(1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_data !== 8'hC3 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: out_data=%h out_valid=%0b required C3 1",
                         i, out_data, out_valid);
            end
        end
        drain(4);
        total++;
        if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'hD4C3B2A1) begin
            bad++;
            $display("FAIL bp_bytes: got %h %h %h %h required D4 C3 B2 A1",
                     rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
        end
    endtask

    task automatic test_reset_midframe();
        rx_q.delete();
        send_byte(8'h00);
        repeat (3) send_byte(8'hFF);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (alu_a !== 32'd0) begin
            bad++;
            $display("FAIL midframe_reset_a: a=%h required 0", alu_a);
        end
        send_frame(8'h05, 32'h12345678, 32'h0F0F0F0F, 1'b0);
        total++;
        if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 4'd5, 32'h12345678, 32'h0F0F0F0F}) begin
            bad++;
            $display("FAIL midframe_second_frame: start=%0b op=%h a=%h b=%h required 1 5 12345678 0F0F0F0F",
                     alu_start, alu_op, alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        pulse_done(32'h1D3B5977);
        drain(4);
        total++;
        if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h77593B1D) begin
            bad++;
            $display("FAIL midframe_bytes: got %h %h %h %h required 77 59 3B 1D",
                     rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
        end
    endtask

    task automatic test_enable();
        ena = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ena_ready: in_ready=%0b required 0", in_ready);
        end
        in_data  = 8'h09;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        ena = 1'b1;
        send_frame(8'h03, 32'hAAAA5555, 32'h00000001, 1'b0);
        total++;
        if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 4'd3, 32'hAAAA5555, 32'h00000001}) begin
            bad++;
            $display("FAIL ena_frozen: start=%0b op=%h a=%h b=%h required 1 3 AAAA5555 1",
                     alu_start, alu_op, alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        pulse_done(32'd0);
        rx_q.delete();
        drain(4);
    endtask

`ifdef ALU_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int s;
        rx_q.delete();
        send_frame(8'h09, 32'h000000F0, 32'h0000003C, 1'b0);
        total++;
        if ({alu_start, err} !== 2'b10) begin
            bad++;
            $display("FAIL csum_good: start=%0b err=%0b required 1 0", alu_start, err);
        end
        @(posedge clk);
        #1;
        pulse_done(32'h00000030);
        drain(4);
        s = start_cnt;
        send_frame(8'h09, 32'h000000F0, 32'h0000003C, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (err !== 1'b1 || start_cnt !== s) begin
            bad++;
            $display("FAIL csum_bad: err=%0b starts=%0d required 1 0", err, start_cnt - s);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_illegal_op();
        test_timeout();
        test_backpressure();
        test_reset_midframe();
        test_enable();
`ifdef ALU_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles spent in WAIT before abort.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  global enable; low freezes all state, and in_ready, alu_start and out_valid read 0.
REQ-005 SHALL have port in_data  input  8  byte-serial request stream.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1; a byte transfers on a cycle with in_valid=1, in_ready=1 and ena=1.
REQ-007 SHALL have port alu_op  output  4  RISC-V ALU op code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
REQ-008 SHALL have ports alu_a and alu_b  output  32 each  operands to the ALU.
REQ-009 SHALL have port alu_start  output  1  one-cycle issue pulse.
REQ-010 SHALL have ports alu_done input 1 and alu_result input 32  ALU completion strobe and result.
REQ-011 SHALL have ports out_data output 8, out_valid output 1 and out_ready input 1  byte-serial result stream.
REQ-012 SHALL have port err  output  1  sticky error flag.

Function
REQ-013 SHALL run FSM states IDLE, LOAD_A, LOAD_B, CHECK, ISSUE, WAIT, SEND.
REQ-014 IDLE SHALL accept the opcode byte, latch bits[3:0] and go to LOAD_A; bits[7:4] are ignored.
REQ-015 LOAD_A and LOAD_B SHALL each accept 4 bytes, little-endian (first byte to [7:0]), using a 2-bit byte counter that wraps to 0 on each state exit.
REQ-016 in_ready SHALL be 1 only in IDLE, LOAD_A, LOAD_B and CHECK.
REQ-017 Without the checksum feature, CHECK SHALL be skipped: after LOAD_B, the FSM goes to ISSUE if the opcode is at most 9, else sets err and returns to IDLE.
REQ-018 ISSUE SHALL assert alu_start for exactly one cycle, then enter WAIT; alu_op, alu_a and alu_b SHALL stay stable from ISSUE until the next opcode byte is accepted.
REQ-019 WAIT SHALL latch alu_result on the first cycle with alu_done=1 and go to SEND; alu_done seen in any other state SHALL be ignored.
REQ-020 WAIT SHALL count cycles; on reaching TIMEOUT_CYCLES without alu_done, it SHALL set err and go to IDLE.
REQ-021 SEND SHALL present 4 result bytes LSB first with out_valid=1; a byte advances only when out_ready=1; after the 4th byte the FSM returns to IDLE.
REQ-022 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-023 err SHALL clear when the next opcode byte is accepted in IDLE; a set and a clear in the same cycle SHALL resolve as set.
REQ-024 Latency SHALL be: alu_start one cycle after the last operand byte is accepted (two with the checksum feature); out_valid one cycle after alu_done.

Reset
REQ-025 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and counters clear, including mid-frame or mid-SEND; the partial frame is discarded.
REQ-026 Reset values SHALL be: in_ready 0 during reset, alu_start 0, alu_op 0, alu_a 0, alu_b 0, out_data 0, out_valid 0, err 0.

Configuration
REQ-027 With ALU_LOADER_CHECKSUM_EN defined, CHECK SHALL accept one extra byte equal to the XOR of the opcode byte and all 8 operand bytes; on mismatch or an illegal opcode, it SHALL set err, skip ISSUE and go to IDLE.
REQ-028 With ALU_LOADER_CHECKSUM_EN undefined, the frame SHALL be 9 bytes and no checksum logic SHALL be synthesised.

Structure
REQ-029 A shared package SHALL hold the op-code enum (4-bit), the FSM state enum, frame-length constants and OP_MAX=9.
REQ-030 One sub-module, alu_result_serializer, SHALL implement the 32-to-8 SEND path with its own valid/ready handshake.

Verification
REQ-031 Frame 00, 05 00 00 00, 07 00 00 00 -> alu_start once with op=0, a=5, b=7; alu_result=0x0000000C -> out bytes 0C 00 00 00.
REQ-032 Opcode 0x0C with 8 operand bytes -> no alu_start, err=1; next frame opcode 00 -> err=0.
REQ-033 alu_done held 0 in WAIT with TIMEOUT_CYCLES=16 -> err=1 on cycle 16, FSM in IDLE, in_ready=1.
REQ-034 out_ready=0 for 5 cycles during SEND byte 1 -> out_data stable, out_valid=1, no byte lost.
REQ-035 rst_n=0 after 3 bytes of operand A, then a full frame -> the second frame alone determines alu_a and alu_b.
REQ-036 With ALU_LOADER_CHECKSUM_EN defined, a frame with a correct checksum -> issue; the same frame with the checksum flipped to 0xFF -> err=1, no alu_start.
